// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU beats into an in-order FIFO and drains one
// register-file write per cycle. Define WB_SCOREBOARD_EN to add the per-register busy scoreboard.
module rf_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              alu_valid,
    input  logic [ADDR_W-1:0]                 alu_rd,
    input  logic [DATA_W-1:0]                 alu_data,
    output logic                              alu_ready,
    input  logic                              lsu_valid,
    input  logic [ADDR_W-1:0]                 lsu_rd,
    input  logic [DATA_W-1:0]                 lsu_data,
    output logic                              lsu_ready,
    output logic                              wren,
    output logic [ADDR_W-1:0]                 rd_addr,
    output logic [DATA_W-1:0]                 reg_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
`ifdef WB_SCOREBOARD_EN
    ,
    input  logic                              iss_valid,
    input  logic [ADDR_W-1:0]                 iss_rd,
    output logic [2**ADDR_W-1:0]              busy
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    wb_entry_t        mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] free;
    logic             lsu_live;
    logic             lsu_push;
    logic             alu_push;
    logic             pop;

    // Credit comes only from the registered count, so a pop never frees a slot early.
    assign free      = CNT_W'(FIFO_DEPTH) - fifo_count;
    assign lsu_live  = lsu_valid & (lsu_rd != '0);
    assign lsu_ready = free >= CNT_W'(1);
    assign alu_ready = free >= (CNT_W'(1) + CNT_W'(lsu_live));
    assign lsu_push  = lsu_live & lsu_ready;
    assign alu_push  = alu_valid & alu_ready & (alu_rd != '0);
    assign pop       = fifo_count != '0;

    // LSU takes the first slot so that an ALU write to the same rd lands last.
    always_ff @(posedge clk) begin
        if (lsu_push)
            mem[wr_ptr] <= '{rd: lsu_rd, data: lsu_data};
        if (alu_push)
            mem[wr_ptr + PTR_W'(lsu_push)] <= '{rd: alu_rd, data: alu_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            wren       <= 1'b0;
            rd_addr    <= '0;
            reg_data   <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PTR_W'(lsu_push) + PTR_W'(alu_push);
            fifo_count <= fifo_count + CNT_W'(lsu_push) + CNT_W'(alu_push) - CNT_W'(pop);
            wren       <= pop;
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                rd_addr  <= mem[rd_ptr].rd;
                reg_data <= mem[rd_ptr].data;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [2**ADDR_W-1:0] busy_nxt;

    // Issue set is applied after the writeback clear so a re-allocation wins.
    always_comb begin
        busy_nxt = busy;
        if (wren)
            busy_nxt[rd_addr] = 1'b0;
        if (iss_valid && (iss_rd != '0))
            busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_nxt;
    end
`endif

endmodule
